perf_trace_tx: RTL and testbench

Synthesisable trace transmitter that sits beside the pipelined CPU core. It counts cycles, hazard stalls and pipeline flushes, and samples the PC periodically. Each sample becomes a 3-word record, which the block streams out over a valid/ready word interface to an external logger. It is the hardware source side of the per-cycle cycle/PC/stall/flush report that the simulation bench consumes.

---
 rtl/perf_trace_pkg.sv | 26 ++
 rtl/perf_trace_fifo.sv | 64 ++++++
 rtl/perf_trace_tx.sv | 141 ++++++++++++++
 tb/tb_perf_trace_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_trace_pkg.sv
// Shared types and widths for the perf trace transmitter.
package perf_trace_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned EVT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] cycle;
        logic [PC_W-1:0]   pc;
        logic [EVT_W-1:0]  stall;
        logic [EVT_W-1:0]  flush;
    } trace_rec_t;

    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2
    } word_idx_t;

    // Saturating +1 for the 16-bit event counters.
    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + EVT_W'(1) : v;
    endfunction

endpackage

// File: rtl/perf_trace_fifo.sv
// Record FIFO; also exposes next-cycle head/empty so the top can register its outputs.
module perf_trace_fifo
    import perf_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push,
    input  trace_rec_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty_next,
    output trace_rec_t head_next
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    trace_rec_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign full        = (count == CNT_W'(DEPTH));
    assign do_pop      = pop && (count != '0);
    assign do_push     = push && (!full || do_pop);
    assign count_next  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign rd_ptr_next = rd_ptr + PTR_W'(do_pop);
    assign empty_next  = (count_next == '0);

    // A lone entry written this cycle is not in mem yet, so forward it.
    always_comb begin
        head_next = mem[rd_ptr_next];
        if (empty_next) begin
            head_next = '0;
        end else if (do_push && (count_next == CNT_W'(1))) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/perf_trace_tx.sv
// CPU trace transmitter: counts cycles/stalls/flushes, samples PC, streams 3-word records.
// Optional cycle limit enabled by defining TRACE_CYCLE_LIMIT_EN.
module perf_trace_tx
    import perf_trace_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SAMPLE_PERIOD = 4,
    parameter int unsigned CYCLE_LIMIT   = 70
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        trace_valid_o,
    output logic [31:0] trace_data_o,
    output logic        trace_last_o,
    input  logic        trace_ready_i,
    output logic        overflow_o,
    output logic        done_o
);

    localparam int unsigned SMP_W = $clog2(SAMPLE_PERIOD);

    logic [DATA_W-1:0] cyc_cnt;
    logic [EVT_W-1:0]  stall_cnt;
    logic [EVT_W-1:0]  flush_cnt;
    logic [SMP_W-1:0]  smp_cnt;
    logic [EVT_W-1:0]  stall_nx;
    logic [EVT_W-1:0]  flush_nx;
    logic              limit_hit;
    logic              active;
    logic              capture;
    logic              handshake;
    logic              pop;
    logic              full;
    logic              empty_next;
    trace_rec_t        rec;
    trace_rec_t        head_next;
    word_idx_t         widx;
    word_idx_t         widx_next;
    logic [DATA_W-1:0] data_next;
    logic              last_next;

`ifdef TRACE_CYCLE_LIMIT_EN
    assign limit_hit = (cyc_cnt == DATA_W'(CYCLE_LIMIT));
`else
    logic [31:0] unused_limit;
    assign unused_limit = 32'(CYCLE_LIMIT);
    assign limit_hit    = 1'b0;
`endif

    assign active    = start_i && !limit_hit;
    assign capture   = active && (smp_cnt == SMP_W'(SAMPLE_PERIOD - 1));
    assign stall_nx  = sat_inc(stall_cnt, stall_i);
    assign flush_nx  = sat_inc(flush_cnt, flush_i);
    assign handshake = trace_valid_o && trace_ready_i;
    assign pop       = handshake && (widx == W2);

    // Captured record carries this cycle's events.
    always_comb begin
        rec       = '0;
        rec.cycle = cyc_cnt;
        rec.pc    = pc_i;
        rec.stall = stall_nx;
        rec.flush = flush_nx;
    end

    perf_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (capture),
        .push_data  (rec),
        .pop        (pop),
        .full       (full),
        .empty_next (empty_next),
        .head_next  (head_next)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            smp_cnt   <= '0;
        end else if (active) begin
            cyc_cnt   <= cyc_cnt + DATA_W'(1);
            stall_cnt <= stall_nx;
            flush_cnt <= flush_nx;
            smp_cnt   <= (smp_cnt == SMP_W'(SAMPLE_PERIOD - 1)) ? '0 : smp_cnt + SMP_W'(1);
        end
    end

    // Word index advance and next-word mux, so the output port registers hold the live word.
    always_comb begin
        widx_next = widx;
        if (handshake) begin
            case (widx)
                W0:      widx_next = W1;
                W1:      widx_next = W2;
                default: widx_next = W0;
            endcase
        end
        data_next = '0;
        last_next = 1'b0;
        if (!empty_next) begin
            case (widx_next)
                W0:      data_next = head_next.cycle;
                W1:      data_next = head_next.pc;
                default: data_next = {head_next.stall, head_next.flush};
            endcase
            last_next = (widx_next == W2);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            widx          <= W0;
            trace_valid_o <= 1'b0;
            trace_data_o  <= '0;
            trace_last_o  <= 1'b0;
            overflow_o    <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            widx          <= widx_next;
            trace_valid_o <= !empty_next;
            trace_data_o  <= data_next;
            trace_last_o  <= last_next;
            overflow_o    <= overflow_o || (capture && full && !pop);
`ifdef TRACE_CYCLE_LIMIT_EN
            done_o        <= limit_hit && empty_next && (widx_next == W0);
`else
            done_o        <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_perf_trace_tx.sv
// Self-checking bench for perf_trace_tx: hand table plus a behavioural scoreboard.
module tb_perf_trace_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SP    = 4;
    localparam int unsigned LIMIT = 70;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        trace_valid_o;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic        trace_ready_i;
    logic        overflow_o;
    logic        done_o;

    perf_trace_tx #(
        .DEPTH         (DEPTH),
        .SAMPLE_PERIOD (SP),
        .CYCLE_LIMIT   (LIMIT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .trace_valid_o (trace_valid_o),
        .trace_data_o  (trace_data_o),
        .trace_last_o  (trace_last_o),
        .trace_ready_i (trace_ready_i),
        .overflow_o    (overflow_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;

    typedef struct {
        logic        st;
        logic        stl;
        logic        fl;
        logic        rdy;
        logic        v;
        logic [31:0] d;
        logic        l;
    } vec_t;

    word_t       q[$];
    vec_t        tbl[13];
    int          n_checks = 0;
    int          n_err    = 0;
    int          mocc;
    int          mwidx;
    logic        movf;
    logic        mdone;
    logic [31:0] mcyc;
    logic [15:0] mstall;
    logic [15:0] mflush;
    logic        tbl_en = 1'b0;
    vec_t        tbl_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic rdy);
        chk("valid", 32'(trace_valid_o), 32'(mocc != 0));
        chk("overflow", 32'(overflow_o), 32'(movf));
        chk("done", 32'(done_o), 32'(mdone));
        if (mocc != 0) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL scoreboard: got word %h with no expected word", trace_data_o);
            end else begin
                chk("data", trace_data_o, q[0].d);
                chk("last", 32'(trace_last_o), 32'(q[0].l));
                if (rdy) void'(q.pop_front());
            end
        end else begin
            chk("idle_data", trace_data_o, 32'h0);
            chk("idle_last", 32'(trace_last_o), 32'h0);
        end
        if (tbl_en) begin
            chk("tbl_valid", 32'(trace_valid_o), 32'(tbl_cur.v));
            chk("tbl_data", trace_data_o, tbl_cur.d);
            chk("tbl_last", 32'(trace_last_o), 32'(tbl_cur.l));
        end
    endtask

    task automatic model_update(input logic rst, input logic st, input logic [31:0] pc,
                                input logic stl, input logic fl, input logic rdy);
        logic        lim;
        logic        act;
        logic        cap;
        logic        hs;
        logic        pop;
        logic [15:0] ns;
        logic [15:0] nf;
        if (!rst) begin
            mocc = 0; mwidx = 0; movf = 1'b0; mdone = 1'b0;
            mcyc = '0; mstall = '0; mflush = '0;
            q.delete();
            return;
        end
`ifdef TRACE_CYCLE_LIMIT_EN
        lim = (mcyc == 32'(LIMIT));
`else
        lim = 1'b0;
`endif
        act = st && !lim;
        cap = act && ((mcyc % SP) == SP - 1);
        ns  = (stl && mstall != 16'hFFFF) ? mstall + 16'd1 : mstall;
        nf  = (fl && mflush != 16'hFFFF) ? mflush + 16'd1 : mflush;
        hs  = (mocc != 0) && rdy;
        pop = hs && (mwidx == 2);
        if (cap) begin
            if (mocc < DEPTH || pop) begin
                q.push_back('{d: mcyc, l: 1'b0});
                q.push_back('{d: pc, l: 1'b0});
                q.push_back('{d: {ns, nf}, l: 1'b1});
                mocc++;
            end else begin
                movf = 1'b1;
            end
        end
        if (pop) mocc--;
        if (hs) mwidx = (mwidx == 2) ? 0 : mwidx + 1;
        if (act) begin
            mcyc   = mcyc + 32'd1;
            mstall = ns;
            mflush = nf;
        end
`ifdef TRACE_CYCLE_LIMIT_EN
        mdone = lim && (mocc == 0) && (mwidx == 0);
`else
        mdone = 1'b0;
`endif
    endtask

    task automatic step(input logic rst, input logic st, input logic [31:0] pc,
                        input logic stl, input logic fl, input logic rdy);
        rst_i = rst; start_i = st; pc_i = pc; stall_i = stl; flush_i = fl; trace_ready_i = rdy;
        @(negedge clk);
        check_outputs(rdy);
        model_update(rst, st, pc, stl, fl, rdy);
        @(posedge clk);
        #1;
        tbl_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0; start_i = 1'b0; pc_i = '0; stall_i = 1'b0; flush_i = 1'b0; trace_ready_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        model_update(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        chk("rst_valid", 32'(trace_valid_o), 32'h0);
        chk("rst_data", trace_data_o, 32'h0);
        chk("rst_last", 32'(trace_last_o), 32'h0);
        chk("rst_overflow", 32'(overflow_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("drained", 32'(q.size()), 32'h0);
    endtask

    initial begin
        // Event-counting stream: stalls on cycles 1,2, flush on cycle 2, pc = 4*cycle.
        tbl[0]  = '{1, 0, 0, 1, 0, 32'h0, 0};
        tbl[1]  = '{1, 1, 0, 1, 0, 32'h0, 0};
        tbl[2]  = '{1, 1, 1, 1, 0, 32'h0, 0};
        tbl[3]  = '{1, 0, 0, 1, 0, 32'h0, 0};
        tbl[4]  = '{1, 0, 0, 1, 1, 32'd3, 0};
        tbl[5]  = '{1, 0, 0, 1, 1, 32'd12, 0};
        tbl[6]  = '{1, 0, 0, 1, 1, 32'h0002_0001, 1};
        tbl[7]  = '{1, 0, 0, 1, 0, 32'h0, 0};
        tbl[8]  = '{1, 0, 0, 1, 1, 32'd7, 0};
        tbl[9]  = '{1, 0, 0, 1, 1, 32'd28, 0};
        tbl[10] = '{1, 0, 0, 1, 1, 32'h0002_0001, 1};
        tbl[11] = '{1, 0, 0, 1, 0, 32'h0, 0};
        tbl[12] = '{1, 0, 0, 1, 1, 32'd11, 0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            tbl_cur = tbl[i];
            tbl_en  = 1'b1;
            step(1'b1, tbl[i].st, 32'(4 * i), tbl[i].stl, tbl[i].fl, tbl[i].rdy);
        end
        drain(16);

        // Basic stream with no events.
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b1);
        drain(16);

        // Backpressure: four records retained, fifth dropped.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b0);
        chk("bp_overflow", 32'(overflow_o), 32'h1);
        drain(16);
        chk("bp_overflow_sticky", 32'(overflow_o), 32'h1);

        // Full FIFO with W2 pop on the capture edge.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'(4 * i), 1'b0, 1'b0, 1'(i >= 17));
        chk("fullpop_overflow", 32'(overflow_o), 32'h0);
        drain(16);

        // Reset while W1 is presented.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'd20, 1'b0, 1'b0, 1'b1);
        chk("midrst_valid", 32'(trace_valid_o), 32'h0);
        chk("midrst_data", trace_data_o, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b1);
        chk("restart_valid", 32'(trace_valid_o), 32'h1);
        chk("restart_w0", trace_data_o, 32'd3);
        drain(16);

        // Random events, PCs, start gaps and backpressure.
        do_reset();
        for (int i = 0; i < 150; i++)
            step(1'b1, 1'($urandom_range(0, 7) != 0), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
        drain(16);

        // Long run past the cycle limit.
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b1);
        drain(16);
`ifdef TRACE_CYCLE_LIMIT_EN
        chk("limit_done", 32'(done_o), 32'h1);
`else
        chk("nolimit_done", 32'(done_o), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
